// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types and one-hot boundary constants for the cycle sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam logic [3:0] STEP_FIRST  = 4'b0001;
  localparam logic [3:0] STEP_LAST   = 4'b1000;
  localparam logic [7:0] COUNT_FIRST = 8'h01;
  localparam logic [7:0] COUNT_LAST  = 8'h80;

endpackage

// File: rtl/onehot_ring.sv
// One-hot rotating ring register with advance enable and synchronous load-to-first.
module onehot_ring #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             load_first,
  output logic [Width-1:0] ring
);

  // Load-to-first has priority so a boundary always restarts at bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ring <= Width'(1);
    end else if (load_first) begin
      ring <= Width'(1);
    end else if (advance) begin
      ring <= {ring[Width-2:0], ring[Width-1]};
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-step / M-cycle sequencer with HALT, stall and runaway recovery.
// Optional instruction length trace enabled by CYCLE_SEQ_LENGTH_TRACE_EN.
module cycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEPS      = 4,
  parameter int unsigned MAX_CYCLES = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_Tick,
  input  logic                  i_Stall,
  input  logic                  i_IR_Fetch,
  input  logic                  i_Halt,
  input  logic                  i_Wake,
  output logic [STEPS-1:0]      o_Cycle_Step,
  output logic [MAX_CYCLES-1:0] o_Cycle_Count,
  output logic                  o_Active,
  output logic                  o_IR_Load,
  output logic                  o_Halted,
  output logic                  o_Overrun,
  output logic [3:0]            o_Last_Length
);

  state_e state_q;
  logic   step_adv;
  logic   mend;
  logic   in_run;
  logic   runaway;
  logic   fetch_end;
  logic   halt_req;
  logic   count_load;
  logic   count_adv;

  assign step_adv  = i_Tick & ~i_Stall;
  assign mend      = step_adv & o_Cycle_Step[STEPS-1];
  assign in_run    = (state_q == StRun);
  // A full-length instruction without a fetch is forced to end as if it had fetched.
  assign runaway   = in_run & ~i_IR_Fetch & o_Cycle_Count[MAX_CYCLES-1];
  assign fetch_end = in_run & (i_IR_Fetch | o_Cycle_Count[MAX_CYCLES-1]);
  assign halt_req  = in_run & i_IR_Fetch & i_Halt & ~i_Wake;

  // Outside RUN the count is parked on the first M-cycle.
  assign count_load = mend & (~in_run | fetch_end);
  assign count_adv  = mend & in_run;

  onehot_ring #(
    .Width (STEPS)
  ) u_step_ring (
    .clk        (i_Clk),
    .rst_n      (i_Reset_n),
    .advance    (step_adv),
    .load_first (1'b0),
    .ring       (o_Cycle_Step)
  );

  onehot_ring #(
    .Width (MAX_CYCLES)
  ) u_count_ring (
    .clk        (i_Clk),
    .rst_n      (i_Reset_n),
    .advance    (count_adv),
    .load_first (count_load),
    .ring       (o_Cycle_Count)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q   <= StBoot;
      o_Active  <= 1'b0;
      o_IR_Load <= 1'b0;
      o_Halted  <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      o_IR_Load <= 1'b0;
      if (mend) begin
        unique case (state_q)
          StBoot: begin
            state_q   <= StRun;
            o_Active  <= 1'b1;
            o_IR_Load <= 1'b1;
          end
          StRun: begin
            if (halt_req) begin
              state_q  <= StHalted;
              o_Active <= 1'b0;
              o_Halted <= 1'b1;
            end else if (fetch_end) begin
              o_IR_Load <= 1'b1;
              if (runaway) o_Overrun <= 1'b1;
            end
          end
          StHalted: begin
            if (i_Wake) begin
              state_q  <= StBoot;
              o_Halted <= 1'b0;
            end
          end
          default: begin
            state_q  <= StBoot;
            o_Active <= 1'b0;
            o_Halted <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CYCLE_SEQ_LENGTH_TRACE_EN
  logic [3:0] len_q;
  logic [3:0] last_len_q;

  // len_q holds the 1-based index of the M-cycle currently executing.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      len_q      <= 4'd1;
      last_len_q <= 4'd0;
    end else if (mend) begin
      if (halt_req) begin
        len_q <= 4'd1;
      end else if ((state_q == StBoot) || fetch_end) begin
        last_len_q <= len_q;
        len_q      <= 4'd1;
      end else if (in_run) begin
        len_q <= len_q + 4'd1;
      end else begin
        len_q <= 4'd1;
      end
    end
  end

  assign o_Last_Length = last_len_q;
`else
  assign o_Last_Length = 4'd0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized self-checking bench for cycle_sequencer against an index-based reference model.
module tb_cycle_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int unsigned STEPS      = 4;
  localparam int unsigned MAX_CYCLES = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  tick;
  logic                  stall;
  logic                  fetch;
  logic                  halt;
  logic                  wake;
  logic [STEPS-1:0]      cyc_step;
  logic [MAX_CYCLES-1:0] cyc_count;
  logic                  active;
  logic                  ir_load;
  logic                  halted;
  logic                  overrun;
  logic [3:0]            last_length;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase/cycle kept as integer indices, mode as 0=boot 1=run 2=halted.
  int m_mode;
  int m_phase;
  int m_mcyc;
  int m_last;
  bit m_active;
  bit m_load;
  bit m_halted;
  bit m_over;

  cycle_sequencer #(
    .STEPS      (STEPS),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_Tick        (tick),
    .i_Stall       (stall),
    .i_IR_Fetch    (fetch),
    .i_Halt        (halt),
    .i_Wake        (wake),
    .o_Cycle_Step  (cyc_step),
    .o_Cycle_Count (cyc_count),
    .o_Active      (active),
    .o_IR_Load     (ir_load),
    .o_Halted      (halted),
    .o_Overrun     (overrun),
    .o_Last_Length (last_length)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_phase  = 0;
    m_mcyc   = 0;
    m_last   = 0;
    m_active = 1'b0;
    m_load   = 1'b0;
    m_halted = 1'b0;
    m_over   = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit t, input bit s, input bit f, input bit h,
                            input bit w);
    bit boundary;
    if (!r) begin
      model_reset();
      return;
    end
    boundary = t && !s && (m_phase == STEPS - 1);
    if (t && !s) m_phase = (m_phase + 1) % STEPS;
    m_load = 1'b0;
    if (!boundary) return;
    case (m_mode)
      0: begin
        m_mode   = 1;
        m_active = 1'b1;
        m_load   = 1'b1;
        m_last   = 1;
        m_mcyc   = 0;
      end
      1: begin
        if (f && h && !w) begin
          m_mode   = 2;
          m_active = 1'b0;
          m_halted = 1'b1;
          m_mcyc   = 0;
        end else if (f || m_mcyc == MAX_CYCLES - 1) begin
          m_load = 1'b1;
          if (!f) m_over = 1'b1;
          m_last = m_mcyc + 1;
          m_mcyc = 0;
        end else begin
          m_mcyc++;
        end
      end
      default: begin
        if (w) begin
          m_mode   = 0;
          m_halted = 1'b0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("step", 32'(cyc_step), 32'(1) << m_phase);
    check("count", 32'(cyc_count), 32'(1) << m_mcyc);
    check("step_onehot", $countones(cyc_step), 1);
    check("count_onehot", $countones(cyc_count), 1);
    check("active", 32'(active), 32'(m_active));
    check("ir_load", 32'(ir_load), 32'(m_load));
    check("halted", 32'(halted), 32'(m_halted));
    check("overrun", 32'(overrun), 32'(m_over));
`ifdef CYCLE_SEQ_LENGTH_TRACE_EN
    check("last_length", 32'(last_length), 32'(m_last));
`else
    check("last_length", 32'(last_length), 32'd0);
`endif
  endtask

  task automatic cycle(input bit r, input bit t, input bit s, input bit f, input bit h,
                       input bit w);
    rst_n = r;
    tick  = t;
    stall = s;
    fetch = f;
    halt  = h;
    wake  = w;
    @(posedge clk);
    model_step(r, t, s, f, h, w);
    #1;
    compare_all();
  endtask

  // One full M-cycle of ticks with the given boundary controls.
  task automatic mcycle(input bit f, input bit h, input bit w);
    for (int i = 0; i < int'(STEPS); i++) cycle(1'b1, 1'b1, 1'b0, f, h, w);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_step", 32'(cyc_step), 32'(STEP_FIRST));
    check("reset_count", 32'(cyc_count), 32'(COUNT_FIRST));

    // Boot fetch.
    mcycle(1'b0, 1'b0, 1'b0);
    check("boot_load", 32'(ir_load), 32'd1);
    // Three-cycle instruction.
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b1, 1'b0, 1'b0);
    // Stall at step 0100.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Runaway instruction.
    for (int i = 0; i < 10; i++) mcycle(1'b0, 1'b0, 1'b0);
    check("overrun_sticky", 32'(overrun), 32'(1));
    // Halt, idle, wake, then halt+wake together.
    mcycle(1'b1, 1'b1, 1'b0);
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b0, 1'b0, 1'b1);
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b1, 1'b1, 1'b1);
    // Reset mid-instruction at step 0100, count 0x04.
    mcycle(1'b0, 1'b0, 1'b0);
    mcycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Generates the one-hot T-step (`o_Cycle_Step`) and one-hot M-cycle (`o_Cycle_Count`) strobes that drive every per-opcode microcode block.
- Decides instruction boundaries from the OR-ed microcode `i_IR_Fetch` and pulses the opcode latch.
- Handles HALT/wake, memory stalls and runaway-instruction recovery.
- Sits between the control-unit decoder and the microcode ROM slices.

Parameters:
- STEPS, 4, T-steps per M-cycle; width of `o_Cycle_Step`.
- MAX_CYCLES, 8, maximum M-cycles per instruction; width of `o_Cycle_Count`.

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  reset, synchronous, active-low.
- i_Tick  in  1  T-step enable; the sequencer advances only on cycles with i_Tick=1.
- i_Stall  in  1  memory wait; freezes all sequencing while high.
- i_IR_Fetch  in  1  OR of all microcode o_IR_Fetch; marks the current M-cycle as the instruction's last.
- i_Halt  in  1  HALT opcode decoded.
- i_Wake  in  1  pending enabled interrupt; ends HALT.
- o_Cycle_Step  out  STEPS  one-hot T-step.
- o_Cycle_Count  out  MAX_CYCLES  one-hot M-cycle index within the instruction.
- o_Active  out  1  an instruction is executing; gates the microcode i_Active.
- o_IR_Load  out  1  one-clock pulse that latches the fetched opcode.
- o_Halted  out  1  in HALTED state.
- o_Overrun  out  1  sticky flag: an instruction exceeded MAX_CYCLES.
- o_Last_Length  out  4  M-cycles of the last completed instruction; only with the optional feature.

Behaviour:
- States: BOOT, RUN, HALTED. All outputs are registered.
- Reset values:
  - state=BOOT
  - o_Cycle_Step=0001, o_Cycle_Count=0x01
  - o_Active=0, o_IR_Load=0, o_Halted=0, o_Overrun=0, o_Last_Length=0
- Step advance: on i_Tick & ~i_Stall, `o_Cycle_Step` rotates left (0001→0010→0100→1000→0001).
- i_Stall=1 holds step, count and state regardless of i_Tick. o_IR_Load is not re-pulsed while stalled.
- M-cycle end (MEND): i_Tick & ~i_Stall & o_Cycle_Step[STEPS-1]. All state/count changes occur only at MEND.
- BOOT: o_Active=0; the M-cycle is a pure opcode fetch. At MEND: o_IR_Load=1 for one clock, count=0x01, go to RUN.
- RUN, MEND with i_IR_Fetch=1: o_IR_Load pulses and count=0x01.
  - If additionally i_Halt=1 and i_Wake=0: go to HALTED, o_Active=0, no o_IR_Load.
- RUN, MEND with i_IR_Fetch=0: count shifts left one place.
- Runaway instruction: if count=0x80 at MEND and i_IR_Fetch=0, it is treated as a fetch (count=0x01, o_IR_Load pulses) and o_Overrun sets. o_Overrun clears only on reset.
- HALTED:
  - o_Halted=1, o_Active=0, count held 0x01.
  - Steps keep rotating so timers referencing step stay phase-aligned.
  - At MEND with i_Wake=1: go to BOOT; the next M-cycle refetches.
- Simultaneous i_Halt & i_Wake at a fetch MEND: wake wins, and the sequencer stays in RUN.
- o_IR_Load is high exactly in the clock after MEND, i.e. one-clock latency from MEND.
- Reset asserted mid-instruction: on the next clock all registers take their reset values; no partial o_IR_Load.
- Invariant: o_Cycle_Step and o_Cycle_Count are always exactly one-hot.

Optional Feature:
- Macro: CYCLE_SEQ_LENGTH_TRACE_EN.
- Defined: a 4-bit counter tracks M-cycles since the last o_IR_Load. On each o_IR_Load, o_Last_Length takes the completed instruction's length (1..8). The BOOT fetch reports 1.
- Undefined: o_Last_Length is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - state enum (BOOT, RUN, HALTED)
  - STEP_FIRST=4'b0001, STEP_LAST=4'b1000
  - COUNT_FIRST=8'h01, COUNT_LAST=8'h80
- Sub-module `onehot_ring`: parameterised width, advance enable, synchronous load-to-first. It is instantiated twice, once for step and once for count.

Test Plan:
- Reset, then 4 ticks → steps 0001,0010,0100,1000; o_IR_Load pulses once after the 4th tick; o_Active=1; count=0x01.
- RUN with i_IR_Fetch asserted in the 3rd M-cycle → count sequence 01,02,04 then 01; exactly one o_IR_Load; o_Last_Length=3 (feature on).
- i_Stall high for 5 clocks at step 0100 with i_Tick=1 → step and count unchanged throughout; sequencing resumes from 0100 on release.
- i_IR_Fetch held 0 for 8 M-cycles → at 0x80 MEND, count=0x01, o_IR_Load pulses, o_Overrun=1 and stays set.
- i_Halt with fetch at MEND → o_Halted=1, o_Active=0, steps keep rotating; i_Wake at a later MEND → BOOT fetch, then o_IR_Load; i_Halt and i_Wake together → stays in RUN.
- i_Reset_n low at step 0100, count 0x04 → next clock: step 0001, count 0x01, state BOOT, o_Overrun=0.
